// File: rtl/cacheline_adaptor_if.sv
// Cache-side and memory-side bus bundle for the cacheline adaptor.
// slave = adaptor view, master = cache/memory environment view.
interface cacheline_adaptor_if #(
  parameter int s_line  = 256,
  parameter int s_burst = 64
);
  logic [s_line-1:0]  line_i;
  logic [s_line-1:0]  line_o;
  logic [31:0]        address_i;
  logic               read_i;
  logic               write_i;
  logic               resp_o;
  logic [s_burst-1:0] burst_i;
  logic [s_burst-1:0] burst_o;
  logic [31:0]        address_o;
  logic               read_o;
  logic               write_o;
  logic               resp_i;

  modport slave (
    input  line_i, address_i, read_i, write_i,
    input  burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o,
    output read_o, write_o
  );

  modport master (
    output line_i, address_i, read_i, write_i,
    output burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o,
    input  read_o, write_o
  );
endinterface

// File: rtl/cacheline_adaptor.sv
// Converts 256-bit cache line requests into 4-beat 64-bit
// memory bursts and returns a one-cycle completion pulse.
module cacheline_adaptor #(
  parameter int s_line  = 256,
  parameter int s_burst = 64
) (
  input  logic clk,
  input  logic rst,
  cacheline_adaptor_if.slave bus
);
  localparam int s_beats = s_line / s_burst;
  localparam int cw      = $clog2(s_beats);
  localparam logic [cw-1:0] last = cw'(s_beats - 1);

  typedef enum logic [1:0] {
    IDLE, READ, WRITE, DONE
  } state_t;

  state_t                           state;
  logic [cw-1:0]                    cnt;
  logic [s_beats-1:0][s_burst-1:0]  line_q;
  logic [31:0]                      addr_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      line_q <= '0;
      addr_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          // write wins when both requests are raised together
          if (bus.write_i) begin
            addr_q <= bus.address_i;
            line_q <= bus.line_i;
            state  <= WRITE;
          end else if (bus.read_i) begin
            addr_q <= bus.address_i;
            state  <= READ;
          end
        end
        READ: begin
          if (bus.resp_i) begin
            line_q[cnt] <= bus.burst_i;
            cnt         <= cnt + 1'b1;
            if (cnt == last)
              state <= DONE;
          end
        end
        WRITE: begin
          if (bus.resp_i) begin
            cnt <= cnt + 1'b1;
            if (cnt == last)
              state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.line_o    = line_q;
  assign bus.address_o = addr_q;
  assign bus.read_o    = (state == READ);
  assign bus.write_o   = (state == WRITE);
  assign bus.resp_o    = (state == DONE);
  assign bus.burst_o   = (state == WRITE) ? line_q[cnt]
                                          : '0;
endmodule
